mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a fetch port and a memory-stage port onto one single-port memory.
// The memory stage wins ties because it holds the older instruction; each
// transaction ends with a one-cycle done pulse carrying rdata and status.
module mem_port_arbiter #(
    parameter int unsigned MEM_SIZE = 1024,
    parameter int unsigned TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        f_req,
    input  logic [63:0] f_addr,
    output logic        f_done,
    output logic [63:0] f_rdata,
    output logic [2:0]  f_status,
    output logic        f_stall,

    input  logic        m_req,
    input  logic        m_wr,
    input  logic [63:0] m_addr,
    input  logic [63:0] m_wdata,
    output logic        m_done,
    output logic [63:0] m_rdata,
    output logic [2:0]  m_status,
    output logic        m_stall,

    output logic        mem_req,
    output logic        mem_wr,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [63:0] mem_rdata
);

    localparam int unsigned AW = 64;
    localparam int unsigned DW = 64;
    localparam int unsigned SW = 3;
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    localparam logic [AW-1:0] MAX_ADDR = AW'(MEM_SIZE - 8);
    localparam logic [SW-1:0] ST_OK    = 3'd1;
    localparam logic [SW-1:0] ST_ERR   = 3'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        F_BUSY = 2'd1,
        M_BUSY = 2'd2,
        ERR    = 2'd3
    } state_t;

    state_t         state;
    state_t         state_nx;

    logic           f_elig;
    logic           m_elig;
    logic           grant;
    logic           grant_m;
    logic [AW-1:0]  sel_addr;
    logic           oor;
    logic           tmo_hit;

    logic           owner_m;
    logic           owner_m_nx;
    logic [CW-1:0]  cnt;
    logic [CW-1:0]  cnt_nx;

    logic           mem_req_nx;
    logic           mem_wr_nx;
    logic [AW-1:0]  mem_addr_nx;
    logic [DW-1:0]  mem_wdata_nx;

    logic           cpl;
    logic [DW-1:0]  cpl_rdata;
    logic [SW-1:0]  cpl_status;

    logic           f_done_nx;
    logic [DW-1:0]  f_rdata_nx;
    logic [SW-1:0]  f_status_nx;
    logic           m_done_nx;
    logic [DW-1:0]  m_rdata_nx;
    logic [SW-1:0]  m_status_nx;

    // A requester whose done pulse is high is not eligible, so it is never re-granted
    assign f_elig   = f_req & ~f_done;
    assign m_elig   = m_req & ~m_done;
    assign grant_m  = m_elig;
    assign grant    = f_elig | m_elig;
    assign sel_addr = grant_m ? m_addr : f_addr;
    assign oor      = (sel_addr > MAX_ADDR);
    assign tmo_hit  = (cnt == CW'(TIMEOUT - 1));

    assign f_stall  = f_req & ~f_done;
    assign m_stall  = m_req & ~m_done;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant) begin
                    if (oor) begin
                        state_nx = ERR;
                    end else begin
                        state_nx = grant_m ? M_BUSY : F_BUSY;
                    end
                end
            end
            F_BUSY, M_BUSY: begin
                if (mem_ack || tmo_hit) begin
                    state_nx = IDLE;
                end
            end
            ERR: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: next values of the registered memory request and completion fields
    always_comb begin
        mem_req_nx   = mem_req;
        mem_wr_nx    = mem_wr;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        owner_m_nx   = owner_m;
        cnt_nx       = cnt;
        cpl          = 1'b0;
        cpl_rdata    = '0;
        cpl_status   = '0;

        case (state)
            IDLE: begin
                if (grant) begin
                    owner_m_nx   = grant_m;
                    mem_addr_nx  = sel_addr;
                    mem_wr_nx    = grant_m & m_wr;
                    mem_wdata_nx = grant_m ? m_wdata : '0;
                    mem_req_nx   = ~oor;
                    cnt_nx       = '0;
                end
            end
            F_BUSY, M_BUSY: begin
                if (mem_ack) begin
                    mem_req_nx = 1'b0;
                    cpl        = 1'b1;
                    cpl_rdata  = mem_wr ? '0 : mem_rdata;
                    cpl_status = ST_OK;
                end else if (tmo_hit) begin
                    mem_req_nx = 1'b0;
                    cpl        = 1'b1;
                    cpl_status = ST_ERR;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            ERR: begin
                cpl        = 1'b1;
                cpl_status = ST_ERR;
            end
            default: ;
        endcase

        f_done_nx   = cpl & ~owner_m;
        m_done_nx   = cpl & owner_m;
        f_rdata_nx  = f_done_nx ? cpl_rdata  : f_rdata;
        f_status_nx = f_done_nx ? cpl_status : f_status;
        m_rdata_nx  = m_done_nx ? cpl_rdata  : m_rdata;
        m_status_nx = m_done_nx ? cpl_status : m_status;
    end

    // Output and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_req   <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            owner_m   <= 1'b0;
            cnt       <= '0;
            f_done    <= 1'b0;
            f_rdata   <= '0;
            f_status  <= '0;
            m_done    <= 1'b0;
            m_rdata   <= '0;
            m_status  <= '0;
        end else begin
            mem_req   <= mem_req_nx;
            mem_wr    <= mem_wr_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            owner_m   <= owner_m_nx;
            cnt       <= cnt_nx;
            f_done    <= f_done_nx;
            f_rdata   <= f_rdata_nx;
            f_status  <= f_status_nx;
            m_done    <= m_done_nx;
            m_rdata   <= m_rdata_nx;
            m_status  <= m_status_nx;
        end
    end

endmodule
